gray_decoder_sync: RTL and testbench

//   Receive side of the binary->gray path: takes a WIDTH-bit gray-coded value from another

---
 rtl/gray_decoder_sync.sv | 179 +++++++++++++++++
 tb/tb_gray_decoder_sync.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_decoder_sync.sv
// gray_decoder_sync: synchronises a gray-coded value from another clock domain,
// decodes it to binary, classifies each change (up / down / illegal jump),
// tracks wrap-arounds and offers every decoded change on a valid/ready port.
module gray_decoder_sync #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             en,
  input  logic             clear_err,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] binary_out,
  output logic             dir_up,
  output logic             step_err,
  output logic             err_sticky,
  output logic             overrun,
  output logic [7:0]       turns
);

  // Priming lasts long enough for the reset value of the chain to be flushed
  // and g_prev to be loaded from the first real synchronised sample.
  localparam int PRIME = SYNC_STAGES + 1;
  localparam int CW    = $clog2(PRIME + 1);

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] g_prev_q, g_prev_d;
  logic [WIDTH-1:0] b_prev_q, b_prev_d;
  logic [CW-1:0]    init_cnt_q, init_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] binary_out_q, binary_out_d;
  logic             dir_up_q, dir_up_d;
  logic             step_err_q, step_err_d;
  logic             err_sticky_q, err_sticky_d;
  logic             overrun_q, overrun_d;
  logic [7:0]       turns_q, turns_d;

  logic [WIDTH-1:0] g_sync;
  logic [WIDTH-1:0] b_sync;
  logic [WIDTH-1:0] diff;
  logic             priming;
  logic             any_change;
  logic             one_hot;
  logic             legal;
  logic             illegal;
  logic             step_up;
  logic             report;
  logic             ovr_set;

  // Synchroniser: plain shift, no logic between stages.
  always_comb begin
    sync_d[0] = gray_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Synchroniser flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign g_sync     = sync_q[SYNC_STAGES-1];
  assign b_sync     = gray2bin(g_sync);
  assign priming    = (init_cnt_q < CW'(PRIME));
  assign diff       = g_sync ^ g_prev_q;
  assign any_change = |diff;
  assign one_hot    = ((diff & (diff - WIDTH'(1))) == '0);
  assign legal      = !priming && any_change && one_hot;
  assign illegal    = !priming && any_change && !one_hot;
  // A legal single-bit gray change is always +1 or -1, so "not +1" means -1.
  assign step_up    = (b_sync == b_prev_q + WIDTH'(1));
  assign report     = (legal || illegal) && en;
  assign ovr_set    = report && out_valid_q && !out_ready;

  // Next-state: change classification, wrap counting, output handshake, sticky flags.
  always_comb begin
    init_cnt_d   = init_cnt_q;
    g_prev_d     = g_sync;
    b_prev_d     = b_sync;
    out_valid_d  = out_valid_q;
    binary_out_d = binary_out_q;
    dir_up_d     = dir_up_q;
    step_err_d   = illegal;
    turns_d      = turns_q;

    if (priming) begin
      init_cnt_d = init_cnt_q + CW'(1);
    end

    if (legal && step_up && (&b_prev_q)) begin
      turns_d = turns_q + 8'd1;
    end else if (legal && !step_up && (b_prev_q == '0)) begin
      turns_d = turns_q - 8'd1;
    end

    if (report) begin
      out_valid_d  = 1'b1;
      binary_out_d = b_sync;
      if (legal) begin
        dir_up_d = step_up;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (illegal) begin
      err_sticky_d = 1'b1;
    end else if (clear_err) begin
      err_sticky_d = 1'b0;
    end else begin
      err_sticky_d = err_sticky_q;
    end

    if (ovr_set) begin
      overrun_d = 1'b1;
    end else if (clear_err) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_cnt_q   <= '0;
      g_prev_q     <= '0;
      b_prev_q     <= '0;
      out_valid_q  <= 1'b0;
      binary_out_q <= '0;
      dir_up_q     <= 1'b0;
      step_err_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      overrun_q    <= 1'b0;
      turns_q      <= '0;
    end else begin
      init_cnt_q   <= init_cnt_d;
      g_prev_q     <= g_prev_d;
      b_prev_q     <= b_prev_d;
      out_valid_q  <= out_valid_d;
      binary_out_q <= binary_out_d;
      dir_up_q     <= dir_up_d;
      step_err_q   <= step_err_d;
      err_sticky_q <= err_sticky_d;
      overrun_q    <= overrun_d;
      turns_q      <= turns_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign binary_out = binary_out_q;
  assign dir_up     = dir_up_q;
  assign step_err   = step_err_q;
  assign err_sticky = err_sticky_q;
  assign overrun    = overrun_q;
  assign turns      = turns_q;

endmodule

// File: tb/tb_gray_decoder_sync.sv
// Bench for gray_decoder_sync: table-driven directed rows, hand-written corner
// sequences and a randomized phase, all compared against a cycle model.
module tb_gray_decoder_sync;

  localparam int W = 4;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] gray_in = '0;
  logic         en = 1'b1;
  logic         clear_err = 1'b0;
  logic         out_ready = 1'b1;
  logic         out_valid;
  logic [W-1:0] binary_out;
  logic         dir_up;
  logic         step_err;
  logic         err_sticky;
  logic         overrun;
  logic [7:0]   turns;

  gray_decoder_sync #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .gray_in(gray_in), .en(en), .clear_err(clear_err),
    .out_ready(out_ready), .out_valid(out_valid), .binary_out(binary_out),
    .dir_up(dir_up), .step_err(step_err), .err_sticky(err_sticky),
    .overrun(overrun), .turns(turns)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] to_bin(input logic [W-1:0] g);
    logic [W-1:0] b = '0;
    for (int k = 0; k < W; k++) b = b ^ (g >> k);
    return b;
  endfunction

  function automatic logic [W-1:0] to_gray(input int n);
    logic [W-1:0] v;
    v = W'(n);
    return v ^ (v >> 1);
  endfunction

  logic [W-1:0] m_q[$];
  int           m_prime;
  logic [W-1:0] m_prev;
  logic         m_valid, m_dir, m_err, m_sticky, m_ovr;
  logic [W-1:0] m_bin;
  logic [7:0]   m_turns;
  logic [W-1:0] m_gs, m_bs, m_bp;
  int           m_hd;
  bit           m_up, m_ovr_now;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q = {};
      for (int k = 0; k < S; k++) m_q.push_back('0);
      m_prime = 0; m_prev = '0;
      m_valid = 0; m_dir = 0; m_err = 0; m_sticky = 0; m_ovr = 0;
      m_bin = '0; m_turns = '0;
    end else begin
      m_gs = m_q.pop_front();
      m_q.push_back(gray_in);
      m_err = 0; m_ovr_now = 0; m_up = 0;
      if (m_prime < S + 1) begin
        m_prev = m_gs;
        m_prime++;
      end else begin
        m_hd = $countones(m_gs ^ m_prev);
        m_bs = to_bin(m_gs);
        m_bp = to_bin(m_prev);
        if (m_hd == 1) begin
          m_up = (((int'(m_bs) - int'(m_bp) + 16) % 16) == 1);
          if (m_up && m_bp == 4'd15) m_turns = m_turns + 8'd1;
          if (!m_up && m_bp == 4'd0) m_turns = m_turns - 8'd1;
        end
        if (m_hd > 1) m_err = 1;
        if (m_hd > 0 && en) begin
          m_ovr_now = m_valid && !out_ready;
          m_bin = m_bs;
          m_valid = 1;
          if (m_hd == 1) m_dir = m_up;
        end else if (m_valid && out_ready) begin
          m_valid = 0;
        end
        m_prev = m_gs;
      end
      if (m_err) m_sticky = 1; else if (clear_err) m_sticky = 0;
      if (m_ovr_now) m_ovr = 1; else if (clear_err) m_ovr = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic [W-1:0] g, input logic e, input logic r, input logic c);
    gray_in = g; en = e; out_ready = r; clear_err = c;
    @(negedge clk);
    chk("model", {15'd0, out_valid, binary_out, dir_up, step_err, err_sticky, overrun, turns},
                 {15'd0, m_valid, m_bin, m_dir, m_err, m_sticky, m_ovr, m_turns});
  endtask

  task automatic do_reset(input logic [W-1:0] g);
    gray_in = g; en = 1; out_ready = 1; clear_err = 0;
    rst = 1;
    #1;
    chk("reset_immediate", {out_valid, binary_out, dir_up, step_err, err_sticky, overrun, turns}, '0);
    @(negedge clk);
    chk("reset_held", {out_valid, binary_out, dir_up, step_err, err_sticky, overrun, turns}, '0);
    rst = 0;
    for (int k = 0; k < 5; k++) cyc(g, 1, 1, 0);
  endtask

  typedef struct {
    bit           do_rst;
    logic [W-1:0] g;
    logic [W-1:0] exp_bin;
    logic         exp_dir;
    logic [7:0]   exp_turns;
  } row_t;

  row_t tbl[9];
  int   lat, pulses, seen, pos;

  initial begin
    tbl[0] = '{1, 4'b0000, 4'd0,  1'b0, 8'd0};
    tbl[1] = '{0, 4'b0001, 4'd1,  1'b1, 8'd0};
    tbl[2] = '{0, 4'b0011, 4'd2,  1'b1, 8'd0};
    tbl[3] = '{0, 4'b0010, 4'd3,  1'b1, 8'd0};
    tbl[4] = '{1, 4'b1000, 4'd0,  1'b0, 8'd0};
    tbl[5] = '{0, 4'b0000, 4'd0,  1'b1, 8'd1};
    tbl[6] = '{0, 4'b1000, 4'd15, 1'b0, 8'd0};
    tbl[7] = '{0, 4'b1001, 4'd14, 1'b0, 8'd0};
    tbl[8] = '{0, 4'b1000, 4'd15, 1'b1, 8'd0};

    // Held value through priming reports nothing.
    do_reset(4'b0110);
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(4'b0110, 1, 1, 0);
      if (out_valid || step_err) seen++;
    end
    chk("prime_quiet", seen, 0);
    chk("prime_bin", binary_out, 4'd0);

    // Table: legal steps, latency, single-cycle valid pulse, wraps.
    foreach (tbl[i]) begin
      if (tbl[i].do_rst) begin
        do_reset(tbl[i].g);
      end else begin
        lat = 0; pulses = 0;
        for (int k = 1; k <= 4; k++) begin
          cyc(tbl[i].g, 1, 1, 0);
          if (out_valid) begin
            pulses++;
            if (lat == 0) lat = k;
          end
        end
        chk("row_latency", lat, 3);
        chk("row_pulse", pulses, 1);
      end
      chk("row_bin", binary_out, tbl[i].exp_bin);
      chk("row_dir", dir_up, tbl[i].exp_dir);
      chk("row_turns", turns, tbl[i].exp_turns);
    end

    // Illegal jump, clear, and clear colliding with a new error.
    do_reset(4'b0001);
    cyc(4'b0010, 1, 1, 0);
    cyc(4'b0010, 1, 1, 0);
    chk("err_early", step_err, 1'b0);
    cyc(4'b0010, 1, 1, 0);
    chk("err_pulse", step_err, 1'b1);
    chk("err_sticky", err_sticky, 1'b1);
    chk("err_bin", binary_out, 4'd3);
    chk("err_valid", out_valid, 1'b1);
    chk("err_turns", turns, 8'd0);
    cyc(4'b0010, 1, 1, 0);
    chk("err_pulse_end", step_err, 1'b0);
    chk("err_sticky_hold", err_sticky, 1'b1);
    cyc(4'b0010, 1, 1, 1);
    chk("err_cleared", err_sticky, 1'b0);
    cyc(4'b0001, 1, 1, 0);
    cyc(4'b0001, 1, 1, 0);
    cyc(4'b0001, 1, 1, 1);
    chk("err_set_wins", err_sticky, 1'b1);
    cyc(4'b0001, 1, 1, 0);
    chk("err_set_wins_hold", err_sticky, 1'b1);

    // Overrun with consumer stalled, then a single transfer.
    do_reset(4'b0000);
    for (int k = 0; k < 4; k++) cyc(4'b0001, 1, 0, 0);
    for (int k = 0; k < 4; k++) cyc(4'b0011, 1, 0, 0);
    chk("ovr_bin", binary_out, 4'd2);
    chk("ovr_valid", out_valid, 1'b1);
    chk("ovr_flag", overrun, 1'b1);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      if (out_valid) pulses++;
      cyc(4'b0011, 1, 1, 0);
    end
    chk("ovr_transfers", pulses, 1);
    chk("ovr_valid_clear", out_valid, 1'b0);
    chk("ovr_flag_hold", overrun, 1'b1);
    cyc(4'b0011, 1, 1, 1);
    chk("ovr_cleared", overrun, 1'b0);

    // Silent tracking with en=0, then re-enable.
    do_reset(4'b0000);
    seen = 0;
    for (int k = 0; k < 4; k++) begin cyc(4'b0001, 0, 1, 0); if (out_valid) seen++; end
    for (int k = 0; k < 4; k++) begin cyc(4'b0011, 0, 1, 0); if (out_valid) seen++; end
    for (int k = 0; k < 4; k++) begin cyc(4'b0011, 1, 1, 0); if (out_valid) seen++; end
    chk("en_silent", seen, 0);
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(4'b0010, 1, 1, 0);
      if (out_valid && binary_out == 4'd3 && dir_up) seen++;
    end
    chk("en_resume", seen, 1);

    // Randomized walk with occasional jumps and mid-stream resets.
    pos = 0;
    do_reset(to_gray(pos));
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 30) pos = ($urandom_range(0, 1) == 1) ? (pos + 1) & 15 : (pos + 15) & 15;
      else if (r < 33) pos = $urandom_range(0, 15);
      cyc(to_gray(pos), $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 60,
          $urandom_range(0, 99) < 5);
      if ($urandom_range(0, 999) < 2) do_reset(to_gray(pos));
    end
    do_reset(to_gray(pos));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
